instruction_issue_unit: RTL

//  Front end for pipeline_processor: fetches 32-bit MIPS R-type words from instruction memory and buffers them in a FIFO.

---
 rtl/instruction_issue_unit.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/instruction_issue_unit.sv
// instruction_issue_unit
//   Front end for pipeline_processor. Fetches 32-bit MIPS R-type words from
//   instruction memory into a small FIFO, decodes the head word into the
//   datapath control fields and issues one instruction per cycle over a
//   valid/ready handshake. Illegal words issue as all-zero NOP bubbles and
//   are counted.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   imem_req/imem_addr          fetch request (held until imem_ack), byte address
//   imem_ack/imem_data          fetch response
//   redirect_valid/redirect_pc  flush FIFO and restart fetch at redirect_pc
//   issue_valid/issue_ready     issue handshake
//   rd, rs, rt, const_amt       register specifiers and shamt
//   amt_sel, logic_func, shift_func, add_sub, final_func   datapath controls
//   read_mode, chip_select      mirror issue_valid; write_mode is always 0
//   illegal_count               saturating count of illegal words issued
module instruction_issue_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_data,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [4:0]       rd,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       const_amt,
    output logic [1:0]       amt_sel,
    output logic [1:0]       logic_func,
    output logic [1:0]       shift_func,
    output logic             add_sub,
    output logic [1:0]       final_func,
    output logic             read_mode,
    output logic             chip_select,
    output logic             write_mode,
    output logic [CNT_W-1:0] illegal_count
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_DROP = 2'd2
    } fetch_state_t;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic         w_launch;

    logic [31:0]  r_pc;
    logic [31:0]  r_req_addr;

    logic [31:0]  r_mem [FIFO_DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [AW:0]  w_count;
    logic         w_empty;
    logic         w_full;
    logic         w_push;
    logic         w_pop;
    logic [31:0]  w_head;

    logic         w_legal;
    logic [4:0]   w_dec_rd, w_dec_rs, w_dec_rt, w_dec_amt;
    logic [1:0]   w_dec_amt_sel, w_dec_logic, w_dec_shift, w_dec_final;
    logic         w_dec_add_sub;

    logic         r_issue_valid;
    logic [4:0]   r_rd, r_rs, r_rt, r_const_amt;
    logic [1:0]   r_amt_sel, r_logic_func, r_shift_func, r_final_func;
    logic         r_add_sub;
    logic [CNT_W-1:0] r_illegal_cnt;

    // Low address bits of a redirect target are ignored by design.
    logic         w_unused_pc_lsbs;
    assign w_unused_pc_lsbs = ^redirect_pc[1:0];

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == DEPTH_L);
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // A redirect discards the same-cycle response and cancels the same-cycle pop.
    assign w_push = (r_state == F_WAIT) && imem_ack && !redirect_valid;
    assign w_pop  = !w_empty && (!r_issue_valid || issue_ready) && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= imem_data;
    end

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        case (r_state)
            F_IDLE: begin
                // Only one request in flight, so the FIFO count alone bounds fetch.
                if (!redirect_valid && !w_full) begin
                    w_state_nxt = F_WAIT;
                    w_launch    = 1'b1;
                end
            end
            F_WAIT: begin
                if (imem_ack)            w_state_nxt = F_IDLE;
                else if (redirect_valid) w_state_nxt = F_DROP;
            end
            F_DROP: begin
                if (imem_ack) w_state_nxt = F_IDLE;
            end
            default: w_state_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= F_IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid)  r_pc <= {redirect_pc[31:2], 2'b00};
            else if (w_push)     r_pc <= r_pc + 32'd4;
            // The request address is captured separately from the PC so it
            // stays put in F_DROP after the PC has moved to the new target.
            if (w_launch)        r_req_addr <= r_pc;
        end
    end

    assign imem_req  = (r_state != F_IDLE);
    assign imem_addr = r_req_addr;

    // ------------------------------------------------------------------
    // Decode of the FIFO head
    // ------------------------------------------------------------------
    always_comb begin
        w_legal       = 1'b0;
        w_dec_rd      = '0;
        w_dec_rs      = '0;
        w_dec_rt      = '0;
        w_dec_amt     = '0;
        w_dec_amt_sel = 2'b00;
        w_dec_logic   = 2'b00;
        w_dec_shift   = 2'b00;
        w_dec_final   = 2'b00;
        w_dec_add_sub = 1'b0;
        if (w_head[31:26] == 6'd0) begin
            case (w_head[5:0])
                6'h20, 6'h21: w_legal = 1'b1;
                6'h22, 6'h23: begin w_legal = 1'b1; w_dec_add_sub = 1'b1; end
                6'h24: begin w_legal = 1'b1; w_dec_final = 2'b01; w_dec_logic = 2'b00; end
                6'h25: begin w_legal = 1'b1; w_dec_final = 2'b01; w_dec_logic = 2'b01; end
                6'h26: begin w_legal = 1'b1; w_dec_final = 2'b01; w_dec_logic = 2'b10; end
                6'h27: begin w_legal = 1'b1; w_dec_final = 2'b01; w_dec_logic = 2'b11; end
                6'h00: begin w_legal = 1'b1; w_dec_final = 2'b10; w_dec_shift = 2'b00; end
                6'h02: begin w_legal = 1'b1; w_dec_final = 2'b10; w_dec_shift = 2'b01; end
                6'h03: begin w_legal = 1'b1; w_dec_final = 2'b10; w_dec_shift = 2'b10; end
                6'h04: begin
                    w_legal = 1'b1; w_dec_final = 2'b10; w_dec_shift = 2'b00; w_dec_amt_sel = 2'b01;
                end
                6'h06: begin
                    w_legal = 1'b1; w_dec_final = 2'b10; w_dec_shift = 2'b01; w_dec_amt_sel = 2'b01;
                end
                6'h07: begin
                    w_legal = 1'b1; w_dec_final = 2'b10; w_dec_shift = 2'b10; w_dec_amt_sel = 2'b01;
                end
                default: w_legal = 1'b0;
            endcase
        end
        if (w_legal) begin
            w_dec_rs  = w_head[25:21];
            w_dec_rt  = w_head[20:16];
            w_dec_rd  = w_head[15:11];
            w_dec_amt = w_head[10:6];
        end else begin
            // Illegal words become a harmless add r0 with every control at 0.
            w_dec_amt_sel = 2'b00;
            w_dec_logic   = 2'b00;
            w_dec_shift   = 2'b00;
            w_dec_final   = 2'b00;
            w_dec_add_sub = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Issue register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_issue_valid <= 1'b0;
            r_rd          <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_const_amt   <= '0;
            r_amt_sel     <= '0;
            r_logic_func  <= '0;
            r_shift_func  <= '0;
            r_add_sub     <= 1'b0;
            r_final_func  <= '0;
            r_illegal_cnt <= '0;
        end else if (redirect_valid || (!w_pop && (!r_issue_valid || issue_ready))) begin
            // Redirect overrides a stall hold; an empty FIFO drains to a bubble.
            r_issue_valid <= 1'b0;
            r_rd          <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_const_amt   <= '0;
            r_amt_sel     <= '0;
            r_logic_func  <= '0;
            r_shift_func  <= '0;
            r_add_sub     <= 1'b0;
            r_final_func  <= '0;
        end else if (w_pop) begin
            r_issue_valid <= 1'b1;
            r_rd          <= w_dec_rd;
            r_rs          <= w_dec_rs;
            r_rt          <= w_dec_rt;
            r_const_amt   <= w_dec_amt;
            r_amt_sel     <= w_dec_amt_sel;
            r_logic_func  <= w_dec_logic;
            r_shift_func  <= w_dec_shift;
            r_add_sub     <= w_dec_add_sub;
            r_final_func  <= w_dec_final;
            if (!w_legal && (r_illegal_cnt != '1))
                r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign issue_valid   = r_issue_valid;
    assign rd            = r_rd;
    assign rs            = r_rs;
    assign rt            = r_rt;
    assign const_amt     = r_const_amt;
    assign amt_sel       = r_amt_sel;
    assign logic_func    = r_logic_func;
    assign shift_func    = r_shift_func;
    assign add_sub       = r_add_sub;
    assign final_func    = r_final_func;
    assign read_mode     = r_issue_valid;
    assign chip_select   = r_issue_valid;
    assign write_mode    = 1'b0;
    assign illegal_count = r_illegal_cnt;

endmodule
